// File: rtl/muldiv_seq_if.sv
// Handshake between the EX-stage sequencer (ID/EX side) and the iterative M-unit.
// The master drives operands and control; the slave returns stall, result and strobe.
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            valid_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            flush_i;
    logic            stall_o;
    logic [XLEN-1:0] result_o;
    logic            result_valid_o;

    modport master (
        output valid_i, funct3_i, rs1_i, rs2_i, flush_i,
        input  stall_o, result_o, result_valid_o
    );

    modport slave (
        input  valid_i, funct3_i, rs1_i, rs2_i, flush_i,
        output stall_o, result_o, result_valid_o
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, one iteration per cycle, sign fixed up when the result is stored.
module muldiv_seq #(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN)
) (
    input logic       clk_i,
    input logic       rst_ni,
    muldiv_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN:0]   acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              stall;
    logic              rvalid;
    logic              sgn1, sgn2, neg1, neg2, in_neg;
    logic              div_by0, div_ovf, special;
    logic [XLEN-1:0]   special_res;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN:0]   mul_next;
    logic [XLEN:0]     div_shift;
    logic signed [XLEN+1:0] div_diff;
    logic [2*XLEN:0]   div_next;
    logic [2*XLEN:0]   acc_step;

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // Multiply: prod holds the 2*XLEN product. Divide: prod = {remainder, quotient}.
    function automatic logic [XLEN-1:0] finish_result(input logic [2:0]        f3,
                                                      input logic              neg,
                                                      input logic [2*XLEN-1:0] prod);
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        p   = neg ? -prod : prod;
        quo = neg ? -prod[XLEN-1:0] : prod[XLEN-1:0];
        rem = neg ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
        if (f3[2]) begin
            return f3[1] ? rem : quo;
        end
        return (f3 == 3'b000) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    always_comb begin
        sgn1    = bus.funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
        sgn2    = bus.funct3_i inside {3'b000, 3'b001, 3'b100, 3'b110};
        neg1    = sgn1 & bus.rs1_i[XLEN-1];
        neg2    = sgn2 & bus.rs2_i[XLEN-1];
        // Remainder takes the dividend's sign; everything else the product/quotient sign.
        in_neg  = (bus.funct3_i[2] & bus.funct3_i[1]) ? neg1 : (neg1 ^ neg2);
        div_by0 = bus.funct3_i[2] & (bus.rs2_i == '0);
        div_ovf = bus.funct3_i[2] & ~bus.funct3_i[0] &
                  (bus.rs1_i == INT_MIN) & (&bus.rs2_i);
        special = div_by0 | div_ovf;
        if (div_by0) begin
            special_res = bus.funct3_i[1] ? bus.rs1_i : '1;
        end else begin
            special_res = bus.funct3_i[1] ? '0 : bus.rs1_i;
        end
    end

    always_comb begin
        mul_sum   = acc_q[2*XLEN:XLEN] + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next  = {1'b0, mul_sum, acc_q[XLEN-1:1]};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = $signed({1'b0, div_shift}) - $signed({2'b00, opb_q});
        if (div_diff[XLEN+1]) begin
            div_next = {div_shift, acc_q[XLEN-2:0], 1'b0};
        end else begin
            div_next = {div_diff[XLEN:0], acc_q[XLEN-2:0], 1'b1};
        end
        acc_step  = f3_q[2] ? div_next : mul_next;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        result_d = result_q;
        stall    = 1'b0;
        rvalid   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.valid_i) begin
                    stall = 1'b1;
                    f3_d  = bus.funct3_i;
                    neg_d = in_neg;
                    opb_d = mag(bus.rs2_i, neg2);
                    acc_d = {{(XLEN+1){1'b0}}, mag(bus.rs1_i, neg1)};
                    cnt_d = '0;
                    if (special) begin
                        result_d = special_res;
                        state_d  = DONE;
                    end else begin
                        state_d  = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    result_d = finish_result(f3_q, neg_q, acc_step[2*XLEN-1:0]);
                    state_d  = DONE;
                end
            end
            DONE: begin
                rvalid  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A killed op leaves no trace: previous result is kept, nothing is strobed.
        if (bus.flush_i) begin
            stall    = 1'b0;
            rvalid   = 1'b0;
            result_d = result_q;
            state_d  = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    // Stall is combinational from valid_i, so it is gated by reset to stay low there.
    assign bus.stall_o        = rst_ni & stall;
    assign bus.result_valid_o = rvalid;
    assign bus.result_o       = result_q;
endmodule
